// File: rtl/sseg_pkg.sv
// Shared helpers for the seven-segment scanner: polarity levels,
// width arithmetic and parameter legality checks.
package sseg_pkg;

   // Logical segment levels before output polarity is applied.
   localparam logic SEG_ON  = 1'b1;
   localparam logic SEG_OFF = 1'b0;

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned x;
      r = 0;
      x = 1;
      while (x < v) begin
         x = x << 1;
         r = r + 1;
      end
      return r;
   endfunction

   // Bits needed to hold 0..v-1, never less than one.
   function automatic int unsigned width_of(input int unsigned v);
      return (clog2(v) == 0) ? 1 : clog2(v);
   endfunction

   // Legal configuration: at least one digit and a non-empty drive window.
   function automatic bit params_ok(input int unsigned n_digits,
                                    input int unsigned ticks,
                                    input int unsigned blank);
      return (n_digits >= 1) && (ticks > blank);
   endfunction

   // Map a logical level onto the pin level for a given polarity.
   function automatic logic drive_level(input logic lit, input logic active_low);
      return lit ^ active_low;
   endfunction

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Display bus between the formatting logic (master) and the scanner (slave).
interface sseg_scan_ctrl_if #(
   parameter int unsigned N_DIGITS = 4,
   parameter int unsigned SEG_W    = 8,
   parameter int unsigned BRIGHT_W = 4
);
   logic [N_DIGITS*SEG_W-1:0] i_segs;
   logic [N_DIGITS-1:0]       i_digit_mask;
   logic [BRIGHT_W-1:0]       i_brightness;
   logic [N_DIGITS-1:0]       o_sseg_enables;
   logic [SEG_W-1:0]          o_sseg;
   logic                      o_frame_start;

   modport master (
      output i_segs, i_digit_mask, i_brightness,
      input  o_sseg_enables, o_sseg, o_frame_start
   );

   modport slave (
      input  i_segs, i_digit_mask, i_brightness,
      output o_sseg_enables, o_sseg, o_frame_start
   );
endinterface

// File: rtl/sseg_slot_timer.sv
// Slot timer: tick counter within a digit slot and digit index across
// the frame, plus slot/frame start flags and the drive-window test.
module sseg_slot_timer
   import sseg_pkg::*;
#(
   parameter int unsigned N_DIGITS        = 4,
   parameter int unsigned TICKS_PER_DIGIT = 1000,
   parameter int unsigned BLANK_TICKS     = 16,
   parameter int unsigned LEN_W           = 11,
   localparam int unsigned IDX_W          = width_of(N_DIGITS)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_ce,
   input  logic [LEN_W-1:0] on_len,
   output logic [IDX_W-1:0] digit_idx,
   output logic             slot_start,
   output logic             frame_start,
   output logic             in_window
);

   localparam int unsigned TICK_W = width_of(TICKS_PER_DIGIT);

   logic [TICK_W-1:0] tick_cnt;

   // Advance tick within the slot; on slot wrap step to the next digit.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         tick_cnt  <= '0;
         digit_idx <= '0;
      end else if (i_ce) begin
         if (tick_cnt == TICK_W'(TICKS_PER_DIGIT - 1)) begin
            tick_cnt <= '0;
            if (digit_idx == IDX_W'(N_DIGITS - 1)) begin
               digit_idx <= '0;
            end else begin
               digit_idx <= digit_idx + 1'b1;
            end
         end else begin
            tick_cnt <= tick_cnt + 1'b1;
         end
      end
   end

   // Slot/frame markers and the lit window after the blanking interval.
   always_comb begin
      slot_start  = (tick_cnt == '0);
      frame_start = slot_start && (digit_idx == '0);
      in_window   = (32'(tick_cnt) >= BLANK_TICKS) &&
                    (32'(tick_cnt) < BLANK_TICKS + 32'(on_len));
   end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scanner: snapshots one digit per slot,
// drives it inside a brightness-scaled window after inter-digit blanking.
module sseg_scan_ctrl
   import sseg_pkg::*;
#(
   parameter int unsigned N_DIGITS        = 4,
   parameter int unsigned SEG_W           = 8,
   parameter int unsigned TICKS_PER_DIGIT = 1000,
   parameter int unsigned BLANK_TICKS     = 16,
   parameter int unsigned BRIGHT_W        = 4,
   parameter int unsigned SEG_ACTIVE_LOW  = 0,
   parameter int unsigned EN_ACTIVE_LOW   = 0
) (
   input logic             i_clk,
   input logic             i_reset,
   input logic             i_ce,
   sseg_scan_ctrl_if.slave bus
);

   localparam int unsigned IDX_W  = width_of(N_DIGITS);
   localparam int unsigned LEN_W  = width_of(TICKS_PER_DIGIT) + 1;
   localparam int unsigned PROD_W = clog2(TICKS_PER_DIGIT) + BRIGHT_W + 1;
   localparam logic SEG_POL = logic'(SEG_ACTIVE_LOW != 0);
   localparam logic EN_POL  = logic'(EN_ACTIVE_LOW != 0);
   localparam logic [SEG_W-1:0]    SEG_IDLE = {SEG_W{drive_level(SEG_OFF, SEG_POL)}};
   localparam logic [N_DIGITS-1:0] EN_IDLE  = {N_DIGITS{drive_level(1'b0, EN_POL)}};

   if (!params_ok(N_DIGITS, TICKS_PER_DIGIT, BLANK_TICKS)) begin : g_bad_params
      $error("sseg_scan_ctrl: need N_DIGITS >= 1 and TICKS_PER_DIGIT > BLANK_TICKS");
   end

   logic [IDX_W-1:0]    digit_idx;
   logic                slot_start;
   logic                frame_start;
   logic                in_window;

   logic [SEG_W-1:0]    pattern_q;
   logic                shown_q;
   logic [LEN_W-1:0]    on_len_q;

   logic [PROD_W-1:0]   prod;
   logic [SEG_W-1:0]    nxt_pattern;
   logic                nxt_shown;
   logic [LEN_W-1:0]    nxt_on_len;
   logic [N_DIGITS-1:0] onehot;
   logic                drive;

   logic [N_DIGITS-1:0] en_q;
   logic [SEG_W-1:0]    sseg_q;
   logic                frame_q;

   sseg_slot_timer #(
      .N_DIGITS        (N_DIGITS),
      .TICKS_PER_DIGIT (TICKS_PER_DIGIT),
      .BLANK_TICKS     (BLANK_TICKS),
      .LEN_W           (LEN_W)
   ) u_timer (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_ce        (i_ce),
      .on_len      (nxt_on_len),
      .digit_idx   (digit_idx),
      .slot_start  (slot_start),
      .frame_start (frame_start),
      .in_window   (in_window)
   );

   // Snapshot values in effect this tick: fresh inputs on slot start so the
   // first tick of a slot already uses the new digit, held values otherwise.
   always_comb begin
      prod        = PROD_W'(TICKS_PER_DIGIT - BLANK_TICKS) *
                    (PROD_W'(bus.i_brightness) + PROD_W'(1));
      nxt_pattern = slot_start ? bus.i_segs[digit_idx*SEG_W +: SEG_W] : pattern_q;
      nxt_shown   = slot_start ? bus.i_digit_mask[digit_idx] : shown_q;
      nxt_on_len  = slot_start ? LEN_W'(prod >> BRIGHT_W) : on_len_q;
      onehot            = '0;
      onehot[digit_idx] = 1'b1;
      drive       = nxt_shown && in_window;
   end

   // Snapshot and output registers; polarity applied only here.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pattern_q <= '0;
         shown_q   <= 1'b0;
         on_len_q  <= '0;
         en_q      <= EN_IDLE;
         sseg_q    <= SEG_IDLE;
         frame_q   <= 1'b0;
      end else begin
         frame_q <= i_ce && frame_start;
         if (i_ce) begin
            pattern_q <= nxt_pattern;
            shown_q   <= nxt_shown;
            on_len_q  <= nxt_on_len;
            en_q      <= drive ? (onehot ^ {N_DIGITS{EN_POL}}) : EN_IDLE;
            sseg_q    <= drive ? (nxt_pattern ^ {SEG_W{SEG_POL}}) : SEG_IDLE;
         end
      end
   end

   assign bus.o_sseg_enables = en_q;
   assign bus.o_sseg         = sseg_q;
   assign bus.o_frame_start  = frame_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: vector table, hand sequences and random run
// against a frame/slot arithmetic model; a second active-low instance
// shares the stimulus.
module tb_sseg_scan_ctrl;

   localparam int unsigned N  = 4;
   localparam int unsigned T  = 8;
   localparam int unsigned B  = 2;
   localparam int unsigned BW = 2;

   logic clk;
   logic rst;
   logic ce;

   int unsigned errors;
   int unsigned checks;

   sseg_scan_ctrl_if #(.N_DIGITS(N), .SEG_W(8), .BRIGHT_W(BW)) bus ();
   sseg_scan_ctrl_if #(.N_DIGITS(N), .SEG_W(8), .BRIGHT_W(BW)) bus_n ();

   assign bus_n.i_segs       = bus.i_segs;
   assign bus_n.i_digit_mask = bus.i_digit_mask;
   assign bus_n.i_brightness = bus.i_brightness;

   sseg_scan_ctrl #(
      .N_DIGITS(N), .SEG_W(8), .TICKS_PER_DIGIT(T), .BLANK_TICKS(B),
      .BRIGHT_W(BW), .SEG_ACTIVE_LOW(0), .EN_ACTIVE_LOW(0)
   ) dut (
      .i_clk(clk), .i_reset(rst), .i_ce(ce), .bus(bus)
   );

   sseg_scan_ctrl #(
      .N_DIGITS(N), .SEG_W(8), .TICKS_PER_DIGIT(T), .BLANK_TICKS(B),
      .BRIGHT_W(BW), .SEG_ACTIVE_LOW(1), .EN_ACTIVE_LOW(1)
   ) dut_n (
      .i_clk(clk), .i_reset(rst), .i_ce(ce), .bus(bus_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: ce ticks since reset give slot and digit directly.
   int unsigned n_ce;
   logic [7:0]  m_pat;
   bit          m_shown;
   int unsigned m_on;
   logic [3:0]  exp_en;
   logic [7:0]  exp_seg;
   logic        exp_fs;

   task automatic model_step(input bit c, input bit r);
      int unsigned tick;
      int unsigned dig;
      if (r) begin
         n_ce = 0; m_pat = '0; m_shown = 0; m_on = 0;
         exp_en = '0; exp_seg = '0; exp_fs = 1'b0;
      end else begin
         exp_fs = 1'b0;
         if (c) begin
            tick = n_ce % T;
            dig  = (n_ce / T) % N;
            if (tick == 0) begin
               m_pat   = bus.i_segs[dig*8 +: 8];
               m_shown = bus.i_digit_mask[dig];
               m_on    = ((T - B) * (32'(bus.i_brightness) + 1)) / (1 << BW);
            end
            exp_fs = (tick == 0) && (dig == 0);
            if (m_shown && tick >= B && tick < B + m_on) begin
               exp_en  = 4'(1 << dig);
               exp_seg = m_pat;
            end else begin
               exp_en  = '0;
               exp_seg = '0;
            end
            n_ce = n_ce + 1;
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks = checks + 1;
      if (act !== expv) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic check_outputs();
      logic [3:0] inv_en;
      logic [7:0] inv_seg;
      inv_en  = ~exp_en;
      inv_seg = ~exp_seg;
      chk("en",     32'(bus.o_sseg_enables), 32'(exp_en));
      chk("seg",    32'(bus.o_sseg), 32'(exp_seg));
      chk("fs",     32'(bus.o_frame_start), 32'(exp_fs));
      chk("en_n",   32'(bus_n.o_sseg_enables), 32'(inv_en));
      chk("seg_n",  32'(bus_n.o_sseg), 32'(inv_seg));
      chk("fs_n",   32'(bus_n.o_frame_start), 32'(exp_fs));
      chk("onehot", 32'($countones(bus.o_sseg_enables) <= 1), 32'd1);
   endtask

   // One clock: inputs already set; model predicts, DUT clocks, compare.
   task automatic cycle(input bit c, input bit r);
      ce  = c;
      rst = r;
      model_step(c, r);
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);
   endtask

   typedef struct {
      logic [1:0] bright;
      logic [3:0] mask;
      int unsigned on0, on1, on2, on3;
   } vec_t;

   vec_t vecs[5];
   int unsigned cnt[4];
   int unsigned fs_cnt;
   int unsigned guard;

   initial begin
      errors = 0;
      checks = 0;
      ce = 1'b0;
      rst = 1'b1;
      bus.i_segs = 32'h44332211;
      bus.i_digit_mask = 4'hF;
      bus.i_brightness = 2'd3;

      vecs[0] = '{bright: 2'd3, mask: 4'b1111, on0: 6, on1: 6, on2: 6, on3: 6};
      vecs[1] = '{bright: 2'd1, mask: 4'b1111, on0: 3, on1: 3, on2: 3, on3: 3};
      vecs[2] = '{bright: 2'd0, mask: 4'b1111, on0: 1, on1: 1, on2: 1, on3: 1};
      vecs[3] = '{bright: 2'd3, mask: 4'b1011, on0: 6, on1: 6, on2: 0, on3: 6};
      vecs[4] = '{bright: 2'd2, mask: 4'b0101, on0: 4, on1: 0, on2: 4, on3: 0};

      // Reset levels, including the active-low instance.
      do_reset();
      chk("rst_en_n",  32'(bus_n.o_sseg_enables), 32'h0000000F);
      chk("rst_seg_n", 32'(bus_n.o_sseg), 32'h000000FF);
      chk("rst_en",    32'(bus.o_sseg_enables), 32'h0);

      // Table: one full frame per vector, lit cycles counted per digit.
      for (int v = 0; v < 5; v++) begin
         bus.i_brightness = vecs[v].bright;
         bus.i_digit_mask = vecs[v].mask;
         bus.i_segs       = 32'h44332211;
         do_reset();
         for (int k = 0; k < 4; k++) cnt[k] = 0;
         fs_cnt = 0;
         for (int i = 0; i < 32; i++) begin
            cycle(1'b1, 1'b0);
            for (int k = 0; k < 4; k++) if (bus.o_sseg_enables[k]) cnt[k]++;
            fs_cnt += 32'(bus.o_frame_start);
         end
         chk("vec_on0", cnt[0], vecs[v].on0);
         chk("vec_on1", cnt[1], vecs[v].on1);
         chk("vec_on2", cnt[2], vecs[v].on2);
         chk("vec_on3", cnt[3], vecs[v].on3);
         chk("vec_fs",  fs_cnt, 1);
      end

      // No tearing: change digit 0 pattern at tick 4 of its slot.
      bus.i_brightness = 2'd3;
      bus.i_digit_mask = 4'hF;
      bus.i_segs       = 32'h44332211;
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
      bus.i_segs = 32'h44332255;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0);
         chk("tear_old", 32'(bus.o_sseg), 32'h11);
         chk("tear_en_n", 32'(bus_n.o_sseg_enables), 32'hE);
         chk("tear_seg_n", 32'(bus_n.o_sseg), 32'hEE);
      end
      for (int i = 0; i < 27; i++) cycle(1'b1, 1'b0);
      chk("tear_new", 32'(bus.o_sseg), 32'h55);
      chk("tear_new_n", 32'(bus_n.o_sseg), 32'hAA);

      // ce 1-in-3 with reset in the middle of the digit 2 slot.
      do_reset();
      guard = 0;
      while (n_ce < 19 && guard < 200) begin
         cycle(guard % 3 == 0, 1'b0);
         guard++;
      end
      chk("reach_d2", n_ce, 19);
      cycle(1'b1, 1'b1);
      chk("rst_mid_en", 32'(bus.o_sseg_enables), 32'h0);
      fs_cnt = 0;
      for (int j = 0; j < 12; j++) begin
         cycle(j % 3 == 1, 1'b0);
         fs_cnt += 32'(bus.o_frame_start);
         if (j == 1) chk("rst_fs_first", 32'(bus.o_frame_start), 32'h1);
      end
      chk("rst_fs_cnt", fs_cnt, 1);

      // Randomized run against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            bus.i_segs       = $urandom;
            bus.i_digit_mask = 4'($urandom);
            bus.i_brightness = 2'($urandom);
         end
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
